reset_seq: RTL and testbench

- Generates the design's block resets: the initiator side of the reset network that the per-domain synchronizers consume.
- Takes the board async active-low reset, a PLL lock indication and a software reset request from the capture-control registers.
- Holds all reset outputs asserted for a stretch period, then releases them one at a time in index order with a fixed gap, so the core releases before the capture logic and the capture logic before the host interface.

---
 rtl/reset_seq_pkg.sv | 20 ++
 rtl/reset_seq_sync.sv | 29 ++
 rtl/reset_seq.sv | 137 +++++++++++++
 tb/tb_reset_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and a
// constant-foldable ceiling-log2 helper used to size internal counters.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Two-flop release synchronizer: asserts asynchronously with reset_,
// deasserts on the second rising clk edge after reset_ goes high.
module reset_seq_sync (
  input  logic clk,
  input  logic reset_,
  output logic sync_out_
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = 1'b1;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out_ = sync_q;

endmodule

// File: rtl/reset_seq.sv
// Block reset sequencer: holds all active-low resets for a stretch period
// with PLL lock, then releases them in index order with a fixed gap.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned NR_OUTPUTS     = 3,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned GAP_CYCLES     = 4
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic [NR_OUTPUTS-1:0] reset_out_,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned CNT_W =
    clog2((STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES) + 1;
  localparam int unsigned IDX_W = clog2(NR_OUTPUTS) + 1;

  logic rst_sync_;

  reset_seq_sync u_sync (
    .clk       (clk),
    .reset_    (reset_),
    .sync_out_ (rst_sync_)
  );

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NR_OUTPUTS-1:0]   rst_out_q, rst_out_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    abort;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    busy_d    = busy_q;
    abort     = !pll_locked || sw_reset_req;

    // Until the synchronized reset releases, every edge reloads the reset state.
    if (!rst_sync_ || (abort && state_q != ST_ASSERT)) begin
      state_d   = ST_ASSERT;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '0;
      done_d    = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rst_out_d = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          if (abort) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
            cnt_d        = '0;
            idx_d        = IDX_W'(1);
            rst_out_d[0] = 1'b1;
            if (NR_OUTPUTS == 1) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            for (int unsigned i = 0; i < NR_OUTPUTS; i++) begin
              if (idx_q == IDX_W'(i)) rst_out_d[i] = 1'b1;
            end
            if (idx_q == IDX_W'(NR_OUTPUTS - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          rst_out_d = '1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end

        default: begin
          state_d   = ST_ASSERT;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign reset_out_ = rst_out_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: directed scenarios plus random lock/request/reset
// traffic, compared each cycle against an elapsed-cycle reference model.
module tb_reset_seq;

  localparam int unsigned N = 3;
  localparam int unsigned S = 16;
  localparam int unsigned G = 4;

  logic         clk = 1'b0;
  logic         reset_;
  logic         pll_locked;
  logic         sw_reset_req;
  logic [N-1:0] reset_out_;
  logic         done;
  logic         busy;

  reset_seq #(
    .NR_OUTPUTS     (N),
    .STRETCH_CYCLES (S),
    .GAP_CYCLES     (G)
  ) dut (
    .clk          (clk),
    .reset_       (reset_),
    .pll_locked   (pll_locked),
    .sw_reset_req (sw_reset_req),
    .reset_out_   (reset_out_),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: edges seen by the synchronizer since reset_ release, and
  // uninterrupted qualifying edges (lock high, no request) since the last restart.
  int sync_cnt = 0;
  int elapsed  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_released();
    int unsigned r;
    if (elapsed < int'(S)) return 0;
    r = 1 + (elapsed - S) / G;
    return (r > N) ? N : r;
  endfunction

  task automatic compare_all(input string tag);
    int unsigned rel;
    logic [31:0] vec;
    rel = exp_released();
    vec = (32'd1 << rel) - 32'd1;
    check({tag, "_out"},  32'(reset_out_), vec);
    check({tag, "_done"}, 32'(done), 32'(rel == N));
    check({tag, "_busy"}, 32'(busy), 32'(rel != N));
  endtask

  task automatic step(input logic lock, input logic req, input string tag);
    pll_locked   = lock;
    sw_reset_req = req;
    @(posedge clk);
    if (!reset_) begin
      sync_cnt = 0;
      elapsed  = 0;
    end else if (sync_cnt < 2) begin
      sync_cnt++;
      elapsed = 0;
    end else if (!lock || req) begin
      elapsed = 0;
    end else if (elapsed < 1000) begin
      elapsed++;
    end
    #1;
    compare_all(tag);
  endtask

  // Sub-cycle reset_ glitch; outputs must clear before any clock edge.
  task automatic async_pulse(input string tag);
    reset_ = 1'b0;
    #1;
    sync_cnt = 0;
    elapsed  = 0;
    compare_all(tag);
    #2;
    reset_ = 1'b1;
  endtask

  int t_b0, t_b1, t_done;

  task automatic run_and_time(input int n, input string tag);
    t_b0 = 0; t_b1 = 0; t_done = 0;
    for (int i = 1; i <= n; i++) begin
      step(1'b1, 1'b0, tag);
      if (reset_out_[0] === 1'b1 && t_b0 == 0) t_b0 = i;
      if (reset_out_[1] === 1'b1 && t_b1 == 0) t_b1 = i;
      if (done === 1'b1 && t_done == 0) t_done = i;
    end
  endtask

  initial begin
    reset_       = 1'b1;
    pll_locked   = 1'b1;
    sw_reset_req = 1'b0;
    #1;
    reset_ = 1'b0;
    #1;
    check("rst_out",  32'(reset_out_), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // Power-up: reset_ low for 5 edges, then count edges from release.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "rst_hold");
    reset_ = 1'b1;
    run_and_time(30, "pwr");
    check("pwr_b0_edge",   32'(t_b0),   32'd18);
    check("pwr_b1_edge",   32'(t_b1),   32'd22);
    check("pwr_done_edge", 32'(t_done), 32'd26);

    // Lock late: lock low for the first 10 edges after release.
    async_pulse("late_rst");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "late_nolock");
    run_and_time(30, "late");
    check("late_b0_edge", 32'(t_b0 + 10), 32'd26);

    // Lock glitch right after bit1 is released.
    async_pulse("glitch_rst");
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0, "glitch_pre");
    check("glitch_pre_out", 32'(reset_out_), 32'd3);
    step(1'b0, 1'b0, "glitch");
    check("glitch_out",  32'(reset_out_), 32'd0);
    check("glitch_done", 32'(done), 32'd0);
    run_and_time(30, "glitch_post");
    check("glitch_b0_edge",   32'(t_b0),   32'd16);
    check("glitch_done_edge", 32'(t_done), 32'd24);

    // Single-cycle software request from DONE.
    step(1'b1, 1'b1, "sw");
    check("sw_out",  32'(reset_out_), 32'd0);
    check("sw_busy", 32'(busy), 32'd1);
    run_and_time(30, "sw_post");
    check("sw_b0_edge",   32'(t_b0),   32'd16);
    check("sw_b1_edge",   32'(t_b1),   32'd20);
    check("sw_done_edge", 32'(t_done), 32'd24);

    // Held request keeps everything asserted.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, "held");
    run_and_time(30, "held_post");
    check("held_b0_edge", 32'(t_b0), 32'd16);

    // Async reset glitch during RELEASE.
    step(1'b1, 1'b1, "mid_req");
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, "mid_pre");
    check("mid_pre_out", 32'(reset_out_), 32'd1);
    async_pulse("mid_async");
    check("mid_async_out", 32'(reset_out_), 32'd0);
    run_and_time(30, "mid_post");
    check("mid_done_edge", 32'(t_done), 32'd26);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) async_pulse("rnd_async");
      step(logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 79) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
